// File: rtl/bcd_counter_pkg.sv
// Shared constants, digit type and digit-validity helper for the BCD up/down counter.
package bcd_counter_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX     = 9;
  localparam int BCD_MIN     = 0;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return d <= bcd_digit_t'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: loads, steps up or down with roll-over, and forwards a step to the next decade.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t ld_val,
  output bcd_digit_t digit,
  output logic       step_out
);

  localparam bcd_digit_t D_MAX = bcd_digit_t'(BCD_MAX);
  localparam bcd_digit_t D_MIN = bcd_digit_t'(BCD_MIN);

  logic at_edge;

  // A decade at 9 (up) or 0 (down) rolls over and carries/borrows into the next one.
  assign at_edge  = up ? (digit == D_MAX) : (digit == D_MIN);
  assign step_out = step_in & at_edge;

  // NOTE: non-blocking, so every decade sees its neighbours' pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= D_MIN;
    end else if (load) begin
      digit <= ld_val;
    end else if (step_in) begin
      if (at_edge) digit <= up ? D_MIN : D_MAX;
      else         digit <= up ? digit + bcd_digit_t'(1) : digit - bcd_digit_t'(1);
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with parallel load, wrap/saturate limit mode,
// terminal-count pulse and invalid-load pulse.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] din,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count,
  output logic                          tc,
  output logic                          load_err
);

  logic              din_ok;
  logic              at_max;
  logic              at_min;
  logic              at_limit;
  logic              load_ok;
  logic              step_req;
  logic              blocked;
  logic [DIGITS:0]   chain;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    din_ok = 1'b1;
    at_max = 1'b1;
    at_min = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      din_ok &= bcd_is_valid(din[k*BCD_DIGIT_W +: BCD_DIGIT_W]);
      at_max &= (count[k*BCD_DIGIT_W +: BCD_DIGIT_W] == bcd_digit_t'(BCD_MAX));
      at_min &= (count[k*BCD_DIGIT_W +: BCD_DIGIT_W] == bcd_digit_t'(BCD_MIN));
    end
  end

  // Any load, valid or not, suppresses counting for that edge.
  assign load_ok  = load & din_ok;
  assign step_req = en & ~load;
  assign at_limit = up ? at_max : at_min;
  assign blocked  = (WRAP == 1'b0) & step_req & at_limit;
  assign chain[0] = step_req & ~blocked;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .step_in  (chain[k]),
      .up       (up),
      .load     (load_ok),
      .ld_val   (din[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit    (count[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .step_out (chain[k+1])
    );
  end

  // A carry out of the top decade is a wrap; a blocked step is a saturation hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= chain[DIGITS] | blocked;
      load_err <= load & ~din_ok;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus and are
// compared against a decimal-integer reference model.
module tb_bcd_updown_counter;

  localparam int D    = 2;
  localparam int W    = 4 * D;
  localparam int MAXV = 99;

  typedef struct {
    int    cnt;
    bit    tc;
    bit    lerr;
    string name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] count_w, count_s;
  logic         tc_w, tc_s, lerr_w, lerr_s;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t e_w, e_s;
  int   m_w = -1;
  int   m_s = -1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(D), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(count_w), .tc(tc_w), .load_err(lerr_w)
  );

  bcd_updown_counter #(.DIGITS(D), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(count_s), .tc(tc_s), .load_err(lerr_s)
  );

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < D; k++) begin
      v[k*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int k = D - 1; k >= 0; k--) begin
      if (v[k*4 +: 4] > 4'd9) return -1;
      n = n * 10 + int'(v[k*4 +: 4]);
    end
    return n;
  endfunction

  // Reference behaviour on plain integers 0..MAXV.
  task automatic model(input bit wrap, inout int n, output exp_t e);
    int v;
    e.tc   = 1'b0;
    e.lerr = 1'b0;
    if (rst) begin
      n = 0;
    end else if (n >= 0) begin
      if (load) begin
        v = bcd_to_int(din);
        if (v < 0) e.lerr = 1'b1;
        else       n = v;
      end else if (en) begin
        if (up) begin
          if (n == MAXV) begin
            e.tc = 1'b1;
            if (wrap) n = 0;
          end else n = n + 1;
        end else begin
          if (n == 0) begin
            e.tc = 1'b1;
            if (wrap) n = MAXV;
          end else n = n - 1;
        end
      end
    end
    e.cnt = n;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [W-1:0] c,
                         input logic t, input logic le);
    check($sformatf("%s/%s count", tag, e.name), 32'(c), 32'(to_bcd(e.cnt)));
    check($sformatf("%s/%s tc", tag, e.name), 32'(t), 32'(e.tc));
    check($sformatf("%s/%s load_err", tag, e.name), 32'(le), 32'(e.lerr));
  endtask

  // Monitor: outputs settle after each posedge and are compared on the following negedge.
  always @(negedge clk) begin
    if (q_w.size() > 0) begin
      e_w = q_w.pop_front();
      compare("wrap", e_w, count_w, tc_w, lerr_w);
    end
    if (q_s.size() > 0) begin
      e_s = q_s.pop_front();
      compare("sat", e_s, count_s, tc_s, lerr_s);
    end
  end

  // One clock of stimulus; optional literal expectations override the model for one DUT.
  task automatic cycle(input bit r, input bit l, input bit e, input bit u,
                       input logic [W-1:0] d, input string name,
                       input int want_cnt = -1, input int want_tc = -1,
                       input int want_le = -1, input bit on_sat = 1'b0);
    exp_t ew, es;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; din = d;
    @(posedge clk);
    model(1'b1, m_w, ew);
    model(1'b0, m_s, es);
    ew.name = name;
    es.name = name;
    if (on_sat) begin
      if (want_cnt >= 0) es.cnt  = want_cnt;
      if (want_tc >= 0)  es.tc   = want_tc[0];
      if (want_le >= 0)  es.lerr = want_le[0];
    end else begin
      if (want_cnt >= 0) ew.cnt  = want_cnt;
      if (want_tc >= 0)  ew.tc   = want_tc[0];
      if (want_le >= 0)  ew.lerr = want_le[0];
    end
    if (m_w >= 0) q_w.push_back(ew);
    if (m_s >= 0) q_s.push_back(es);
  endtask

  task automatic do_load(input int v, input string name);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, to_bcd(v), name, v, 0, 0);
  endtask

  initial begin
    int r, sel;
    logic [W-1:0] d;
    bit l, e, u;

    // Reset from unknown state, then reset while loading and counting at 57.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, '0, "reset", 0, 0, 0);
    do_load(57, "load57");
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, "rst_at_57", 0, 0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, "rst_at_57s", 0, 0, 0, 1'b1);

    // Wrap upward through 99.
    do_load(98, "load98");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "up_98", 99, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "up_99", 0, 1, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "up_00", 1, 0, 0);

    // Wrap downward through 00, then a borrow across the decade.
    do_load(1, "load01");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "dn_01", 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "dn_00", 99, 1, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "dn_99", 98, 0, 0);
    do_load(20, "load20");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "dn_20", 19, 0, 0);

    // Saturation at 99, then release downward.
    do_load(99, "load99");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "sat_up1", 99, 1, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "sat_up2", 99, 1, 0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "sat_dn", 98, 0, 0, 1'b1);
    do_load(0, "load00");
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "sat_lo", 0, 1, 0, 1'b1);

    // Invalid load keeps count and pulses load_err once; valid load beats en.
    do_load(42, "load42");
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h3A, "bad_3A", 42, 0, 1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h37, "load37", 37, 0, 0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, "bad_A5", 37, 0, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, "hold37", 37, 0, 0);

    // Direction toggled every cycle.
    do_load(50, "load50");
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "tog1", 51, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "tog2", 50, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "tog3", 51, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, "tog4", 50, 0, 0);

    // Reset on an edge that would otherwise wrap: no pulse, counting resumes next edge.
    do_load(99, "load99b");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, '0, "rst_wrap", 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0, "resume", 1, 0, 0);

    // Randomised traffic with slowly changing direction and limit-biased loads.
    u = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 7);
      case (sel)
        0:       d = 8'h99;
        1:       d = 8'h00;
        2:       d = {4'($urandom_range(10, 15)), 4'($urandom)};
        3:       d = 8'($urandom);
        default: d = to_bcd($urandom_range(0, 99));
      endcase
      l = (r >= 2) && (r < 12);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) u = ~u;
      cycle(r < 2, l, e, u, d, $sformatf("rnd%0d", i));
    end

    for (int i = 0; i < 10 && (q_w.size() + q_s.size()) > 0; i++) @(posedge clk);
    @(posedge clk);
    check("drain", 32'(q_w.size() + q_s.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, giving the number of cascaded BCD decades (legal 1..8).
REQ-002 SHALL have parameter WRAP, default 1, selecting the limit mode: 1 = wrap around, 0 = saturate at the limit.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port en, input, 1 bit: count enable, one step per clock while high.
REQ-007 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-008 SHALL have port load, input, 1 bit: parallel load strobe.
REQ-009 SHALL have port din, input, 4*DIGITS bits: parallel load value, digit 0 (LSD) in bits [3:0].
REQ-010 SHALL have port count, output, 4*DIGITS bits: registered BCD count, digit 0 in bits [3:0].
REQ-011 SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-012 SHALL have port load_err, output, 1 bit: registered invalid-load pulse.

Function
REQ-013 SHALL apply per-edge priority rst > load > en; with en=0 and load=0, count SHALL hold.
REQ-014 SHALL, on load=1 with every din digit <= 9, set count=din at that edge; tc=0 and load_err=0 for that cycle.
REQ-015 SHALL, on load=1 with any din digit > 9, leave count unchanged and set load_err=1 for exactly one cycle; en is ignored that cycle.
REQ-016 SHALL, on an up step: increment digit 0; increment digit k only when all lower digits equal 9; roll any digit at 9 to 0.
REQ-017 SHALL, on a down step: decrement digit 0; decrement digit k only when all lower digits equal 0; roll any digit at 0 to 9.
REQ-018 SHALL sample up every enabled cycle; a direction change takes effect on the same edge, with no dead cycle.
REQ-019 SHALL, with WRAP=1, step all-9s to all-0s (up) or all-0s to all-9s (down), and assert tc on the edge that performs the wrap.
REQ-020 SHALL, with WRAP=0, hold count at all-9s (up) or all-0s (down) when a step would leave the range, and assert tc on each such blocked enabled edge.
REQ-021 SHALL keep tc high for exactly one cycle per terminal event, registered in the same edge as count, with zero added latency.
REQ-022 SHALL keep count a valid BCD value in every cycle after the first reset.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, force count=0, tc=0 and load_err=0 at that edge, regardless of load, en or din.
REQ-024 SHALL, on reset asserted mid-count or mid-load, drop the pending operation with no tc or load_err pulse; counting resumes on the first edge with rst=0.
REQ-025 SHALL use reset as the only initialisation mechanism; the output state before the first reset is unspecified.

Structure
REQ-026 SHALL place BCD_DIGIT_W=4, BCD_MAX=9, BCD_MIN=0 and the digit-vector typedef in the shared package bcd_counter_pkg.
REQ-027 SHALL build the count from a generated chain of DIGITS instances of sub-module bcd_digit (ports: clk, rst, step_in, up, load, ld_val, digit, step_out).
REQ-028 SHALL keep the limit and saturation logic, tc and load_err in the top level; bcd_digit SHALL contain no WRAP logic.

Verification (DIGITS=2)
REQ-029 SHALL check: rst=1 while count=57 -> count=00 next edge, tc=0, load_err=0.
REQ-030 SHALL check: WRAP=1, load 98, en=1, up=1 for 3 cycles -> 99, 00 (tc=1 on this edge only), 01.
REQ-031 SHALL check: WRAP=1, load 01, en=1, up=0 for 3 cycles -> 00, 99 (tc=1), 98; load 20 then one down step -> 19.
REQ-032 SHALL check: WRAP=0, count=99, en=1, up=1 for 2 cycles -> count stays 99, tc=1 on both edges; then up=0 -> 98, tc=0.
REQ-033 SHALL check: din=0x3A with load=1 and en=1 at count=42 -> count=42, load_err=1 for one cycle; then load=1 and en=1 with din=0x37 -> count=37 and no step.
REQ-034 SHALL check: up toggled every cycle with en=1 from 50 -> 51, 50, 51, 50, with tc=0 throughout.
